// File: rtl/mux4_operand_stager.sv
// mux4_operand_stager
//
// Staging and sequencing stage around the 32-bit yMux4to1 combinational mux.
// Holds the four mux operands in registers, drives the mux select either once
// or as an ascending scan up to index 3, captures the mux output one cycle
// after each select change and offers it on a valid/ready output port.
//
// Optional feature macro: MUX4_OPERAND_STAGER_CHECK_EN
//   defined   -> z is compared against an internal selection of a0..a3 at
//                every capture; a mismatch sets the sticky chk_err flag.
//   undefined -> no comparator, chk_err tied to 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data operand write port (honoured in IDLE only)
//   wr_err                one-cycle pulse per dropped write
//   start/scan/sel_in     run request: single select or scan sel_in..3
//   a0..a3                operand registers, wired to the mux inputs
//   c                     mux select
//   z                     mux output, fed back for capture
//   out_data/out_sel      captured word and the select that produced it
//   out_valid/out_ready   output handshake
//   busy                  high whenever the sequencer is not in IDLE
//   chk_err               sticky self-check error
module mux4_operand_stager #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_err,
  input  logic             start,
  input  logic             scan,
  input  logic [1:0]       sel_in,
  output logic [WIDTH-1:0] a0,
  output logic [WIDTH-1:0] a1,
  output logic [WIDTH-1:0] a2,
  output logic [WIDTH-1:0] a3,
  output logic [1:0]       c,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             chk_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] SEL_LAST   = 2'd3;

  // Reference selection used by the self-check comparator.
  function automatic logic [WIDTH-1:0] sel_word(
    input logic [1:0]       s,
    input logic [WIDTH-1:0] w0,
    input logic [WIDTH-1:0] w1,
    input logic [WIDTH-1:0] w2,
    input logic [WIDTH-1:0] w3
  );
    logic [WIDTH-1:0] r;
    case (s)
      2'd0:    r = w0;
      2'd1:    r = w1;
      2'd2:    r = w2;
      2'd3:    r = w3;
      default: r = w0;
    endcase
    return r;
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] ops_r [4];
  logic [1:0]       c_r;
  logic             scan_r;
  logic [WIDTH-1:0] out_data_r;
  logic [1:0]       out_sel_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             wr_err_r;
  logic             chk_err_r;

  logic             start_run_s;
  logic             capture_s;
  logic             accept_s;
  logic             advance_s;
  logic             wr_commit_s;
  logic             wr_drop_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; an unreachable encoding falls back to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_SETTLE;
        else       state_nxt_s = ST_IDLE;
      end
      ST_SETTLE: begin
        state_nxt_s = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (out_ready) begin
          if (scan_r && (c_r != SEL_LAST)) state_nxt_s = ST_SETTLE;
          else                             state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PRESENT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Per-state control strobes for the datapath registers.
  always_comb begin
    start_run_s = 1'b0;
    capture_s   = 1'b0;
    accept_s    = 1'b0;
    advance_s   = 1'b0;
    wr_commit_s = 1'b0;
    wr_drop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        start_run_s = start;
        wr_commit_s = wr_en;
      end
      ST_SETTLE: begin
        capture_s = 1'b1;
        wr_drop_s = wr_en;
      end
      ST_PRESENT: begin
        accept_s  = out_ready;
        advance_s = out_ready & scan_r & (c_r != SEL_LAST);
        wr_drop_s = wr_en;
      end
      default: begin
        wr_drop_s = wr_en;
      end
    endcase
  end

  // Operand registers; a write in the start cycle lands before SETTLE samples z.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) ops_r[i] <= {WIDTH{1'b0}};
    end else if (wr_commit_s) begin
      ops_r[wr_addr] <= wr_data;
    end
  end

  // Select, capture and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_r         <= 2'd0;
      scan_r      <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_sel_r   <= 2'd0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      wr_err_r    <= 1'b0;
    end else begin
      busy_r   <= (state_nxt_s != ST_IDLE);
      wr_err_r <= wr_drop_s;
      if (start_run_s) begin
        c_r    <= sel_in;
        scan_r <= scan;
      end else if (advance_s) begin
        c_r <= c_r + 2'd1;
      end
      if (capture_s) begin
        out_data_r  <= z;
        out_sel_r   <= c_r;
        out_valid_r <= 1'b1;
      end else if (accept_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

`ifdef MUX4_OPERAND_STAGER_CHECK_EN
  // Sticky comparison of the external mux against the internal selection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_r <= 1'b0;
    end else if (capture_s &&
                 (z != sel_word(c_r, ops_r[0], ops_r[1], ops_r[2], ops_r[3]))) begin
      chk_err_r <= 1'b1;
    end
  end
`else
  assign chk_err_r = 1'b0;
`endif

  assign a0        = ops_r[0];
  assign a1        = ops_r[1];
  assign a2        = ops_r[2];
  assign a3        = ops_r[3];
  assign c         = c_r;
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign wr_err    = wr_err_r;
  assign chk_err   = chk_err_r;

endmodule

// File: doc/mux4_operand_stager.md
# mux4_operand_stager

Upstream staging and sequencing stage for the 32-bit `yMux4to1` datapath mux. It holds the four mux operands in registers and drives the mux select `c`, either once or as a 0→3 scan. It then captures the mux output `z` and presents each selected word on a valid/ready output port. The same block gives the lab datapath and its benches a deterministic, cycle-accurate source and sink around the combinational mux.

## Interface
- `WIDTH`, 32, operand/result width; must match the mux instance parameter.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: operand write strobe.
- `wr_addr` in 2: operand index 0..3.
- `wr_data` in WIDTH: operand value.
- `wr_err` out 1: one-cycle pulse when a write is dropped.
- `start` in 1: begin a selection run, sampled in IDLE only.
- `scan` in 1: 0 = single select of `sel_in`; 1 = scan from `sel_in` up to 3.
- `sel_in` in 2: first select index.
- `a0`..`a3` out WIDTH each: operand registers, wired to the mux inputs.
- `c` out 2: mux select.
- `z` in WIDTH: mux output, fed back.
- `out_data` out WIDTH: captured mux output.
- `out_sel` out 2: select index that produced `out_data`.
- `out_valid` out 1: output valid.
- `out_ready` in 1: downstream ready.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `chk_err` out 1: sticky self-check error (see Configuration).

## Operation
- Reset (asynchronous, `rst_n`=0) sets:
  - `a0`..`a3` = 0, `c` = 0, `out_data` = 0, `out_sel` = 0
  - `out_valid` = 0, `busy` = 0, `wr_err` = 0, `chk_err` = 0
  - FSM = IDLE
- Writes:
  - In IDLE, `wr_en` writes `wr_data` into register `wr_addr` at the clock edge.
  - Outside IDLE, the write is dropped and `wr_err` pulses high for exactly one cycle.
- FSM states: IDLE, SETTLE, PRESENT.
  - IDLE → SETTLE when `start`=1. At that edge: `c` ← `sel_in`, `scan` is latched, `busy` ← 1.
  - SETTLE → PRESENT unconditionally. At that edge: `out_data` ← `z`, `out_sel` ← `c`, `out_valid` ← 1.
  - PRESENT holds while `out_ready`=0. `out_data`, `out_sel` and `c` stay stable.
  - PRESENT with `out_ready`=1 completes a transfer:
    - If latched scan=1 and `c`≠3: `c` ← `c`+1, `out_valid` ← 0, go to SETTLE.
    - Otherwise: `out_valid` ← 0, `busy` ← 0, go to IDLE. `c` holds its last value.
- Boundaries:
  - Scan starting at `sel_in`=3 produces exactly one word. `c` never wraps past 3.
  - `start` outside IDLE is ignored.
  - `wr_en` and `start` in the same IDLE cycle: the write commits at that edge. SETTLE therefore sees the new operand value.
  - Reset asserted mid-run aborts immediately. All outputs take their reset values; no partial transfer completes.

## Timing
- Latency from the `start` edge to `out_valid`=1 is 2 cycles.
- Each subsequent scan word appears 2 cycles after the accepting `out_ready` edge.
- With `out_ready` held at 1, a 4-word scan completes in 8 cycles from `start`.
- `z` is sampled only at the SETTLE→PRESENT edge. The mux has one full cycle to settle after `c` changes.
- `out_valid` never drops without a transfer, except on reset.
- `out_valid` is low in SETTLE.

## Configuration
- Macro: `MUX4_OPERAND_STAGER_CHECK_EN`.
- Defined:
  - At each SETTLE→PRESENT edge the block compares `z` with its own internal selection of `a0`..`a3` by `c`.
  - On mismatch, `chk_err` ← 1 and stays set until reset.
- Undefined: the comparator is not built, and `chk_err` is tied to 0.

## Test plan
- Reset and write:
  - Reset, then write a0=0x11111111, a1=0x22222222, a2=0x33333333, a3=0x44444444.
  - Required: `a0`..`a3` read back these values; `busy`=0; `out_valid`=0.
- Single select:
  - `start`=1, `scan`=0, `sel_in`=2, `out_ready`=1.
  - Required: `out_valid` high 2 cycles later with `out_data`=0x33333333 and `out_sel`=2, then IDLE.
- Full scan with backpressure:
  - `scan`=1, `sel_in`=0, `out_ready` low for 3 cycles on each word.
  - Required: words 0x11111111, 0x22222222, 0x33333333, 0x44444444 in order; `out_data` stable while stalled; `busy` drops after word 3.
- Dropped write:
  - `wr_en`, `wr_addr`=1, `wr_data`=0xDEADBEEF while `busy`.
  - Required: one-cycle `wr_err`; `a1` unchanged.
- Reset mid-run:
  - Assert `rst_n`=0 during PRESENT of a scan.
  - Required: `out_valid`=0, `c`=0, `a0`..`a3`=0 immediately, without waiting for a clock edge.
- Check feature (`MUX4_OPERAND_STAGER_CHECK_EN` defined):
  - Force `z` to 0 while `c`=1 and `a1`=0x22222222.
  - Required: `chk_err`=1 and remains set until reset.
